// File: rtl/mac_feed_seq_pkg.sv
// Shared constants for the MAC feed sequencer: MAC mode encodings,
// config field width and the sequencer state encoding.
package mac_feed_seq_pkg;

    // Width of the MAC config field: [1:0] mode, [MAC_CONF_W-1] accumulate select
    localparam int unsigned MAC_CONF_W = 3;

    // MAC lane modes (2'b11 is accepted but makes the MAC produce 0)
    localparam logic [1:0] MODE_SINGLE = 2'b00;
    localparam logic [1:0] MODE_DUAL   = 2'b01;
    localparam logic [1:0] MODE_QUAD   = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_RUN,
        ST_DRAIN,
        ST_HOLD
    } mac_state_e;

endpackage

// File: rtl/mac_feed_seq.sv
// Upstream sequencer for one MAC lane: takes a job command and an operand
// stream, drives the MAC pins from registers, waits out the MAC pipeline
// and returns the captured result on a valid/ready port.
module mac_feed_seq
    import mac_feed_seq_pkg::*;
#(
    parameter int unsigned MIN_W   = 8,
    parameter int unsigned ACC_W   = 32,
    parameter int unsigned CONF_W  = MAC_CONF_W,
    parameter int unsigned LEN_W   = 8,
    parameter int unsigned MAC_LAT = 1
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [1:0]              cmd_mode,
    input  logic                    cmd_acc,
    input  logic [ACC_W-1:0]        cmd_init,
    input  logic [LEN_W-1:0]        cmd_len,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [4*MIN_W-1:0]      in_a,
    input  logic [MIN_W-1:0]        in_b,
    output logic                    mac_rst,
    output logic                    mac_en,
    output logic [MIN_W-1:0]        mac_a0,
    output logic [MIN_W-1:0]        mac_a1,
    output logic [MIN_W-1:0]        mac_a2,
    output logic [MIN_W-1:0]        mac_a3,
    output logic [MIN_W-1:0]        mac_b3,
    output logic [ACC_W+CONF_W-1:0] mac_cfg,
    input  logic [ACC_W-1:0]        mac_c,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ACC_W-1:0]        out_data
);

    mac_state_e              r_state;
    mac_state_e              w_state_nxt;
    logic [LEN_W-1:0]        r_cnt;
    logic [LEN_W-1:0]        r_len;
    logic                    r_mac_rst;
    logic                    r_mac_en;
    logic [4*MIN_W-1:0]      r_mac_a;
    logic [MIN_W-1:0]        r_mac_b;
    logic [ACC_W+CONF_W-1:0] r_mac_cfg;
    logic [ACC_W+CONF_W-1:0] w_cfg_nxt;
    logic                    r_out_valid;
    logic [ACC_W-1:0]        r_out_data;
    logic                    w_cmd_hs;
    logic                    w_in_hs;
    logic                    w_drain_done;

    // Place the A lanes onto the MAC pins as {a3,a2,a1,a0} for the given mode;
    // the narrow modes fill from a3 downwards and zero the unused pins.
    function automatic logic [4*MIN_W-1:0] pack_lanes(input logic [1:0] mode,
                                                      input logic [4*MIN_W-1:0] a);
        logic [4*MIN_W-1:0] lanes;
        lanes = '0;
        case (mode)
            MODE_SINGLE: lanes[4*MIN_W-1:3*MIN_W] = a[MIN_W-1:0];
            MODE_DUAL:   lanes[4*MIN_W-1:2*MIN_W] = a[2*MIN_W-1:0];
            MODE_QUAD:   lanes = a;
            default:     lanes = '0;
        endcase
        return lanes;
    endfunction

    assign cmd_ready    = (r_state == ST_IDLE);
    assign in_ready     = (r_state == ST_RUN);
    assign w_cmd_hs     = (r_state == ST_IDLE) && cmd_valid;
    assign w_in_hs      = (r_state == ST_RUN) && in_valid;
    assign w_drain_done = (r_state == ST_DRAIN) && (r_cnt == LEN_W'(MAC_LAT));

    assign mac_rst   = r_mac_rst;
    assign mac_en    = r_mac_en;
    assign mac_a0    = r_mac_a[MIN_W-1:0];
    assign mac_a1    = r_mac_a[2*MIN_W-1:MIN_W];
    assign mac_a2    = r_mac_a[3*MIN_W-1:2*MIN_W];
    assign mac_a3    = r_mac_a[4*MIN_W-1:3*MIN_W];
    assign mac_b3    = r_mac_b;
    assign mac_cfg   = r_mac_cfg;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

    // Config word for the incoming command: {init, acc, zeros, mode}
    always_comb begin
        w_cfg_nxt                          = '0;
        w_cfg_nxt[ACC_W+CONF_W-1:CONF_W]   = cmd_init;
        w_cfg_nxt[CONF_W-1]                = cmd_acc;
        w_cfg_nxt[1:0]                     = cmd_mode;
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (cmd_valid) w_state_nxt = (cmd_len != '0) ? ST_INIT : ST_HOLD;
            ST_INIT:  w_state_nxt = ST_RUN;
            ST_RUN:   if (w_in_hs && (r_cnt == LEN_W'(1))) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (w_drain_done) w_state_nxt = ST_HOLD;
            ST_HOLD:  if (out_ready) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_state_nxt;
    end

    // Latch the job parameters on command acceptance; cfg then holds until the next job
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_len     <= '0;
            r_mac_cfg <= '0;
        end else if (w_cmd_hs) begin
            r_len     <= cmd_len;
            r_mac_cfg <= w_cfg_nxt;
        end
    end

    // Beat counter in RUN (counts down to 0); reused as the pipeline wait counter in DRAIN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else begin
            case (r_state)
                ST_INIT:  r_cnt <= r_len;
                ST_RUN:   if (w_in_hs) r_cnt <= r_cnt - LEN_W'(1);
                ST_DRAIN: r_cnt <= r_cnt + LEN_W'(1);
                default:  r_cnt <= '0;
            endcase
        end
    end

    // MAC pin drive: one-cycle reset pulse in INIT, enable and operands one cycle after each beat
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mac_rst <= 1'b1;
            r_mac_en  <= 1'b0;
            r_mac_a   <= '0;
            r_mac_b   <= '0;
        end else begin
            r_mac_rst <= (w_state_nxt == ST_INIT);
            r_mac_en  <= w_in_hs;
            if (w_in_hs) begin
                r_mac_a <= pack_lanes(r_mac_cfg[1:0], in_a);
                r_mac_b <= in_b;
            end
        end
    end

    // Result port: zero-length jobs answer straight from the command, others capture mac_c
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (w_cmd_hs && (cmd_len == '0)) begin
            r_out_valid <= 1'b1;
            r_out_data  <= cmd_acc ? cmd_init : '0;
        end else if (w_drain_done) begin
            r_out_valid <= 1'b1;
            r_out_data  <= mac_c;
        end else if ((r_state == ST_HOLD) && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

endmodule
